// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cmp_pkg
// Purpose : Shared types, defaults and helpers for the comparator feeder.
// Revision: 1.0 - initial release
// ============================================================================
package cmp_pkg;

    localparam int CMP_DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } cmp_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_feeder_if.sv
`default_nettype none
// ============================================================================
// Module  : cmp_feeder_if
// Purpose : Window intake, comparator operand/result and upstream result bus.
// Revision: 1.0 - initial release
// ============================================================================
interface cmp_feeder_if
    import cmp_pkg::*;
#(
    parameter int DATA_W = CMP_DATA_W,
    parameter int WIN    = 4
) ();

    logic                    win_valid;
    logic                    win_ready;
    logic [WIN*DATA_W-1:0]   win_data;

    logic [DATA_W-1:0]       cmp_in_a;
    logic                    cmp_in_valid;
    logic                    cmp_in_first;
    logic                    cmp_in_last;
    logic                    cmp_res_valid;
    logic [DATA_W-1:0]       cmp_res;

    logic                    res_valid;
    logic                    res_ready;
    logic [DATA_W-1:0]       res_data;
    logic                    res_err;

    // The feeder is the initiator towards the comparator.
    modport master (
        input  win_valid, win_data, cmp_res_valid, cmp_res, res_ready,
        output win_ready, cmp_in_a, cmp_in_valid, cmp_in_first, cmp_in_last,
               res_valid, res_data, res_err
    );

    modport slave (
        output win_valid, win_data, cmp_res_valid, cmp_res, res_ready,
        input  win_ready, cmp_in_a, cmp_in_valid, cmp_in_first, cmp_in_last,
               res_valid, res_data, res_err
    );

endinterface
`default_nettype wire

// File: rtl/cmp_win_shift.sv
`default_nettype none
// ============================================================================
// Module  : cmp_win_shift
// Purpose : Parallel-load window register shifting one element per step,
//           element 0 (LSBs) presented first.
// Revision: 1.0 - initial release
// ============================================================================
module cmp_win_shift #(
    parameter int DATA_W = 4,
    parameter int WIN    = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  load_i,
    input  wire logic                  shift_i,
    input  wire logic [WIN*DATA_W-1:0] data_i,
    output logic      [DATA_W-1:0]     elem_o
);

    logic [WIN*DATA_W-1:0] shreg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else if (load_i) begin
            shreg_q <= data_i;
        end else if (shift_i) begin
            shreg_q <= {{DATA_W{1'b0}}, shreg_q[WIN*DATA_W-1:DATA_W]};
        end
    end

    assign elem_o = shreg_q[DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/cmp_feeder.sv
`default_nettype none
// ============================================================================
// Module  : cmp_feeder
// Purpose : Serialises one operand window to the comparator, waits (with
//           timeout) for its result and returns it upstream.
// Revision: 1.0 - initial release
// ============================================================================
module cmp_feeder
    import cmp_pkg::*;
#(
    parameter int DATA_W  = CMP_DATA_W,
    parameter int WIN     = 4,
    parameter int TIMEOUT = 16
) (
    input  wire logic    clk,
    input  wire logic    rst,
    cmp_feeder_if.master bus,
    output logic         busy
);

    localparam int CNT_W = clog2(WIN);
    localparam int TMR_W = clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    cmp_state_e          state_q;
    logic [CNT_W-1:0]    elem_cnt_q;
    logic [TMR_W-1:0]    timer_q;
    logic [DATA_W-1:0]   res_data_q;
    logic                res_err_q;
    logic [DATA_W-1:0]   elem;
    logic                win_accept;
    logic                sending;

    assign bus.win_ready = (state_q == IDLE) && !rst;
    assign win_accept    = bus.win_valid && bus.win_ready;
    assign sending       = (state_q == SEND);

    cmp_win_shift #(
        .DATA_W (DATA_W),
        .WIN    (WIN)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load_i  (win_accept),
        .shift_i (sending),
        .data_i  (bus.win_data),
        .elem_o  (elem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            elem_cnt_q <= '0;
            timer_q    <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_accept) begin
                        elem_cnt_q <= '0;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (elem_cnt_q == LAST_IDX) begin
                        elem_cnt_q <= '0;
                        timer_q    <= '0;
                        // A zero-latency comparator answers during the last element.
                        if (bus.cmp_res_valid) begin
                            res_data_q <= bus.cmp_res;
                            res_err_q  <= 1'b0;
                            state_q    <= RESP;
                        end else begin
                            state_q    <= WAIT;
                        end
                    end else begin
                        elem_cnt_q <= elem_cnt_q + 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.cmp_res_valid) begin
                        res_data_q <= bus.cmp_res;
                        res_err_q  <= 1'b0;
                        state_q    <= RESP;
                    end else if (timer_q == TMR_LAST) begin
                        res_data_q <= '0;
                        res_err_q  <= 1'b1;
                        state_q    <= RESP;
                    end else begin
                        timer_q    <= timer_q + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.res_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmp_in_valid = sending;
    assign bus.cmp_in_a     = sending ? elem : '0;
    assign bus.cmp_in_first = sending && (elem_cnt_q == '0);
    assign bus.cmp_in_last  = sending && (elem_cnt_q == LAST_IDX);

    assign bus.res_valid    = (state_q == RESP);
    assign bus.res_data     = res_data_q;
    assign bus.res_err      = res_err_q;
    assign busy             = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cmp_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_cmp_feeder
// Purpose : Scoreboard bench for cmp_feeder with a max-finding comparator model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cmp_feeder;

    localparam int DW  = 4;
    localparam int WIN = 4;
    localparam int TO  = 16;

    typedef struct packed {
        logic [DW-1:0] a;
        logic          first;
        logic          last;
    } op_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          err;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    int n_checks = 0;
    int n_err    = 0;

    op_t  ops_q[$];
    res_t res_q[$];

    int cmp_mode  = 0;   // 0: answer 1 cycle after last, 1: during last, 2: never
    bit stray_req = 1'b0;

    always #5 clk = ~clk;

    cmp_feeder_if #(.DATA_W(DW), .WIN(WIN)) bus ();

    cmp_feeder #(
        .DATA_W  (DW),
        .WIN     (WIN),
        .TIMEOUT (TO)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Comparator model: running maximum of the window elements.
    initial begin : cmp_model
        logic [DW-1:0] acc;
        logic [DW-1:0] pend_val;
        logic [DW-1:0] r;
        bit            pend;
        bit            v;
        acc = '0; pend_val = '0; pend = 1'b0;
        bus.cmp_res_valid = 1'b0;
        bus.cmp_res       = '0;
        forever begin
            @(posedge clk);
            #1;
            v = 1'b0;
            r = '0;
            if (pend) begin
                v = 1'b1; r = pend_val; pend = 1'b0;
            end
            if (bus.cmp_in_valid) begin
                if (bus.cmp_in_first || bus.cmp_in_a > acc) acc = bus.cmp_in_a;
                if (bus.cmp_in_last) begin
                    if (cmp_mode == 1) begin
                        v = 1'b1; r = acc;
                    end else if (cmp_mode == 0) begin
                        pend = 1'b1; pend_val = acc;
                    end
                end
            end
            if (stray_req) begin
                v = 1'b1; r = 4'hF; stray_req = 1'b0;
            end
            bus.cmp_res_valid = v;
            bus.cmp_res       = r;
        end
    end

    // Monitor: pops the scoreboard as the DUT emits operands and results.
    always @(negedge clk) begin
        op_t  eo;
        res_t er;
        if (bus.cmp_in_valid) begin
            if (ops_q.size() == 0) begin
                chk("op_extra", 1, 0);
            end else begin
                eo = ops_q.pop_front();
                chk("op_a", bus.cmp_in_a, eo.a);
                chk("op_first", bus.cmp_in_first, eo.first);
                chk("op_last", bus.cmp_in_last, eo.last);
            end
        end else begin
            chk("op_idle_zero", {bus.cmp_in_a, bus.cmp_in_first, bus.cmp_in_last}, 0);
        end
        if (bus.res_valid && bus.res_ready) begin
            if (res_q.size() == 0) begin
                chk("res_extra", 1, 0);
            end else begin
                er = res_q.pop_front();
                chk("res_data", bus.res_data, er.d);
                chk("res_err", bus.res_err, er.err);
            end
        end
    end

    task automatic run_win(input logic [15:0] d, input int mode, input int hold,
                           input bit stray_send, input int exp_res_lat, input int exp_rdy_lat);
        int            n;
        bit            ok;
        res_t          er;
        op_t           eo;
        logic [DW-1:0] e;
        logic [DW-1:0] mx;
        mx = '0;
        for (int i = 0; i < WIN; i++) begin
            e        = d[i*DW +: DW];
            eo.a     = e;
            eo.first = (i == 0);
            eo.last  = (i == WIN - 1);
            ops_q.push_back(eo);
            if (i == 0 || e > mx) mx = e;
        end
        if (mode == 2) begin
            er.d = '0; er.err = 1'b1;
        end else begin
            er.d = mx; er.err = 1'b0;
        end
        res_q.push_back(er);
        cmp_mode = mode;

        @(posedge clk); #1;
        bus.res_ready = (hold == 0);
        bus.win_valid = 1'b1;
        bus.win_data  = d;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (bus.win_ready) ok = 1'b1;
        end
        chk("accept", ok, 1);
        if (!ok) begin
            bus.win_valid = 1'b0;
            return;
        end
        if (stray_send) stray_req = 1'b1;
        @(posedge clk); #1;
        bus.win_valid = 1'b0;
        bus.win_data  = 16'($urandom);

        n = 0; ok = 1'b0;
        while (!ok && n < 64) begin
            @(negedge clk);
            n++;
            if (bus.res_valid) ok = 1'b1;
        end
        chk("res_lat", n, exp_res_lat);

        if (hold > 0) begin
            for (int k = 1; k < hold; k++) begin
                @(posedge clk); #1;
                bus.win_valid = 1'b1;
                bus.win_data  = 16'hFFFF;
                @(negedge clk);
                n++;
                chk("bp_valid", bus.res_valid, 1);
                chk("bp_data", bus.res_data, er.d);
                chk("bp_err", bus.res_err, er.err);
                chk("bp_win_ready", bus.win_ready, 0);
            end
            @(posedge clk); #1;
            bus.win_valid = 1'b0;
            bus.res_ready = 1'b1;
        end

        ok = 1'b0;
        while (!ok && n < 96) begin
            @(negedge clk);
            n++;
            if (bus.win_ready) ok = 1'b1;
        end
        chk("rdy_lat", n, exp_rdy_lat);
    endtask

    task automatic stray_idle();
        @(negedge clk);
        stray_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("stray_idle_busy", busy, 0);
        chk("stray_idle_resv", bus.res_valid, 0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        op_t  eo;
        bit   seen;
        logic [15:0] rd;
        int   m;
        bus.win_valid = 1'b0;
        bus.win_data  = '0;
        bus.res_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_win_ready", bus.win_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", {bus.res_data, bus.res_err}, 0);
        chk("rst_cmp_valid", bus.cmp_in_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_win_ready", bus.win_ready, 1);

        run_win(16'h2311, 0, 0, 1'b0, 6, 7);     // basic
        run_win(16'h5A39, 1, 0, 1'b0, 5, 6);     // zero-latency, WAIT skipped
        run_win(16'h4C17, 2, 0, 1'b0, 21, 22);   // timeout
        stray_idle();
        run_win(16'h7C21, 0, 5, 1'b0, 6, 12);    // result backpressure
        stray_idle();
        run_win(16'h1E3B, 0, 0, 1'b1, 6, 7);     // strobe in first SEND cycle

        // Reset during the second element aborts the window.
        rd = 16'h8642;
        for (int i = 0; i < 2; i++) begin
            eo.a = rd[i*DW +: DW]; eo.first = (i == 0); eo.last = 1'b0;
            ops_q.push_back(eo);
        end
        cmp_mode = 0;
        @(posedge clk); #1;
        bus.win_valid = 1'b1;
        bus.win_data  = rd;
        @(negedge clk);
        chk("rst_mid_accept", bus.win_ready, 1);
        @(posedge clk); #1;
        bus.win_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_cmp_valid", bus.cmp_in_valid, 0);
        chk("rst_mid_busy", busy, 0);
        seen = 1'b0;
        repeat (24) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1'b1;
        end
        chk("rst_mid_no_res", seen, 0);
        run_win(16'h3D95, 0, 0, 1'b0, 6, 7);

        for (int i = 0; i < 4; i++) begin
            rd = 16'($urandom);
            m  = int'($urandom_range(0, 1));
            run_win(rd, m, 0, 1'b0, (m == 1) ? 5 : 6, (m == 1) ? 6 : 7);
        end

        repeat (3) @(posedge clk);
        chk("ops_drained", ops_q.size(), 0);
        chk("res_drained", res_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
